// File: rtl/div32u16_seq.sv
// div32u16_seq: restoring shift-subtract divider, 32-bit dividend by 16-bit divisor,
// one quotient bit per cycle, with optional skipping of the low quotient bits.
module div32u16_seq #(
    parameter int SKIP_LSB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] O,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        ovf
);
    localparam int N = 16 - SKIP_LSB;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_rem;
    logic [15:0] r_shf;
    logic [15:0] r_quo;
    logic [15:0] r_b;
    logic [4:0]  r_cnt;
    logic [15:0] r_q;
    logic [15:0] r_r;
    logic        r_ovf;

    logic        w_accept;
    logic        w_ovf_in;
    logic        w_last;
    logic        w_ge;
    logic [16:0] w_trial;
    logic [16:0] w_rem_next;
    logic [15:0] w_quo_next;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign Q          = r_q;
    assign R          = r_r;
    assign ovf        = r_ovf;
    assign w_accept   = in_valid & in_ready;
    // A high half at or above the divisor means the quotient cannot fit; B == 0 lands here too.
    assign w_ovf_in   = (O[31:16] >= B);
    assign w_last     = (r_cnt == LAST);
    // The partial remainder is always below B, so shifting it left by one never loses a set bit.
    assign w_trial    = (r_rem << 1) | 17'(r_shf[15]);
    assign w_ge       = (w_trial >= {1'b0, r_b});
    assign w_rem_next = w_ge ? w_trial - {1'b0, r_b} : w_trial;
    assign w_quo_next = (r_quo << 1) | 16'(w_ge);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept -> CALC (or straight to DONE on overflow), N iterations, then hold until taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_ovf_in ? DONE : CALC) : IDLE;
            CALC:    w_next = w_last ? DONE : CALC;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate in CALC, and update results only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_shf <= '0;
            r_quo <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_b   <= B;
                        r_rem <= {1'b0, O[31:16]};
                        r_shf <= O[15:0];
                        r_quo <= '0;
                        r_cnt <= '0;
                        if (w_ovf_in) begin
                            r_q   <= 16'hFFFF;
                            r_r   <= 16'h0000;
                            r_ovf <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_shf <= r_shf << 1;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_q   <= 16'(w_quo_next << SKIP_LSB);
                        r_r   <= 16'(w_rem_next);
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div32u16_seq.sv
// tb_div32u16_seq: randomized and directed checks of two divider instances (SKIP_LSB 0 and 4) against an arithmetic model.
module tb_div32u16_seq;
    logic        clk;
    logic        rst_n;
    logic        iv0, ir0, ov0, ordy0, f0;
    logic [31:0] o0;
    logic [15:0] b0, q0, r0;
    logic        iv4, ir4, ov4, ordy4, f4;
    logic [31:0] o4;
    logic [15:0] b4, q4, r4;
    int          total;
    int          bad;

    div32u16_seq #(.SKIP_LSB(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .O(o0), .B(b0),
        .out_valid(ov0), .out_ready(ordy0), .Q(q0), .R(r0), .ovf(f0)
    );

    div32u16_seq #(.SKIP_LSB(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .O(o4), .B(b4),
        .out_valid(ov4), .out_ready(ordy4), .Q(q4), .R(r4), .ovf(f4)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, Q, R} straight from the arithmetic definition.
    function automatic logic [32:0] model(input logic [31:0] o, input logic [15:0] b, input int sk);
        logic [31:0] oo;
        if ({16'h0, o[31:16]} >= {16'h0, b}) return {1'b1, 16'hFFFF, 16'h0000};
        oo = o >> sk;
        return {1'b0, 16'((oo / {16'h0, b}) << sk), 16'(oo % {16'h0, b})};
    endfunction

    function automatic logic ready(input int s);
        return (s == 0) ? ir0 : ir4;
    endfunction

    function automatic logic vld(input int s);
        return (s == 0) ? ov0 : ov4;
    endfunction

    function automatic logic [32:0] res(input int s);
        return (s == 0) ? {f0, q0, r0} : {f4, q4, r4};
    endfunction

    task automatic drive(input int s, input logic v, input logic [31:0] o, input logic [15:0] b);
        if (s == 0) begin
            iv0 = v; o0 = o; b0 = b;
        end else begin
            iv4 = v; o4 = o; b4 = b;
        end
    endtask

    task automatic set_ordy(input int s, input logic v);
        if (s == 0) ordy0 = v;
        else ordy4 = v;
    endtask

    // Present one operation, wait for the accept edge, then count cycles until out_valid.
    task automatic run_op(input int s, input logic [31:0] o, input logic [15:0] b,
                          output logic [32:0] got, output int lat);
        int w;
        drive(s, 1'b1, o, b);
        w = 0;
        while (!ready(s) && w < 100) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        drive(s, 1'b0, o, b);
        lat = 1;
        while (!vld(s) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        got = res(s);
    endtask

    task automatic test_reset();
        for (int s = 0; s <= 4; s += 4) begin
            total++;
            if (ready(s) !== 1'b1 || vld(s) !== 1'b0 || res(s) !== 33'h0) begin
                bad++;
                $display("FAIL reset_state skip=%0d: in_ready=%b out_valid=%b {ovf,Q,R}=%h, want 1 0 %h",
                         s, ready(s), vld(s), res(s), 33'h0);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] vo [6] = '{32'h00000064, 32'hFFFE0001, 32'h12345678, 32'h00070000, 32'h00010000, 32'h12345678};
        logic [15:0] vb [6] = '{16'h0007, 16'hFFFF, 16'h0000, 16'h0007, 16'h0003, 16'h0000};
        int          vs [6] = '{0, 0, 0, 0, 4, 4};
        logic [32:0] got, exp;
        int          lat, elat;
        for (int i = 0; i < 6; i++) begin
            exp  = model(vo[i], vb[i], vs[i]);
            elat = exp[32] ? 1 : 17 - vs[i];
            run_op(vs[i], vo[i], vb[i], got, lat);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL directed_result #%0d O=%h B=%h skip=%0d: {ovf,Q,R}=%h, want %h", i, vo[i], vb[i], vs[i], got, exp);
            end
            total++;
            if (lat !== elat) begin
                bad++;
                $display("FAIL directed_latency #%0d: got %0d, want %0d", i, lat, elat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] o;
        logic [15:0] b;
        logic [32:0] got, exp;
        int          lat;
        for (int s = 0; s <= 4; s += 4) begin
            for (int i = 0; i < 30; i++) begin
                b = 16'($urandom);
                if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
                o = $urandom;
                if (b != 0 && $urandom_range(0, 4) != 0) o[31:16] = o[31:16] % b;
                exp = model(o, b, s);
                run_op(s, o, b, got, lat);
                total++;
                if (got !== exp || lat !== (exp[32] ? 1 : 17 - s)) begin
                    bad++;
                    $display("FAIL random skip=%0d O=%h B=%h: {ovf,Q,R}=%h lat=%0d, want %h lat=%0d",
                             s, o, b, got, lat, exp, exp[32] ? 1 : 17 - s);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] got1, got2, e1, e2;
        logic        rdy, seen;
        int          k, w;
        for (int s = 0; s <= 4; s += 4) begin
            e1 = model(32'h0000BEEF, 16'h0123, s);
            e2 = model(32'h00420777, 16'h1001, s);
            drive(s, 1'b1, 32'h0000BEEF, 16'h0123);
            w = 0;
            while (!ready(s) && w < 100) begin
                @(posedge clk); #1; w++;
            end
            @(posedge clk); #1;
            drive(s, 1'b1, 32'h00420777, 16'h1001);
            k = 0;
            seen = 1'b0;
            got1 = '0;
            do begin
                @(negedge clk);
                rdy = ready(s);
                if (vld(s) && !seen) begin
                    got1 = res(s);
                    seen = 1'b1;
                end
                @(posedge clk);
                k++;
            end while (!rdy && k < 100);
            #1;
            drive(s, 1'b0, 32'h0, 16'h0);
            total++;
            if (k !== 18 - s) begin
                bad++;
                $display("FAIL b2b_period skip=%0d: got %0d, want %0d", s, k, 18 - s);
            end
            total++;
            if (got1 !== e1 || !seen) begin
                bad++;
                $display("FAIL b2b_first skip=%0d: {ovf,Q,R}=%h seen=%b, want %h", s, got1, seen, e1);
            end
            w = 0;
            while (!vld(s) && w < 100) begin
                @(posedge clk); #1; w++;
            end
            got2 = res(s);
            total++;
            if (got2 !== e2) begin
                bad++;
                $display("FAIL b2b_second skip=%0d: {ovf,Q,R}=%h, want %h", s, got2, e2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] got, exp;
        int          lat;
        exp = model(32'h00000064, 16'h0007, 0);
        set_ordy(0, 1'b0);
        run_op(0, 32'h00000064, 16'h0007, got, lat);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL bp_result: {ovf,Q,R}=%h, want %h", got, exp);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 32'h00300001, 16'hFFFF);
            @(posedge clk); #1;
            total++;
            if (ov0 !== 1'b1 || ir0 !== 1'b0 || {f0, q0, r0} !== exp) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b {ovf,Q,R}=%h, want 1 0 %h",
                         i, ov0, ir0, {f0, q0, r0}, exp);
            end
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 16'h0);
        set_ordy(0, 1'b1);
        @(posedge clk); #1;
        total++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", ir0, ov0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [32:0] got, exp;
        int          lat, w, stale;
        drive(0, 1'b1, 32'h00000064, 16'h0007);
        w = 0;
        while (!ir0 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 16'h0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || {f0, q0, r0} !== 33'h0) begin
            bad++;
            $display("FAIL reset_mid_async: in_ready=%b out_valid=%b {ovf,Q,R}=%h, want 1 0 0", ir0, ov0, {f0, q0, r0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov0) stale++;
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL reset_mid_stale: out_valid seen %0d cycles, want 0", stale);
        end
        exp = model(32'h00000064, 16'h0007, 0);
        run_op(0, 32'h00000064, 16'h0007, got, lat);
        total++;
        if (got !== exp || lat !== 17) begin
            bad++;
            $display("FAIL reset_mid_fresh: {ovf,Q,R}=%h lat=%0d, want %h lat=17", got, lat, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        total = 0;
        bad = 0;
        drive(0, 1'b0, 32'h0, 16'h0);
        drive(4, 1'b0, 32'h0, 16'h0);
        set_ordy(0, 1'b1);
        set_ordy(4, 1'b1);
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        @(negedge clk);
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
